// File: rtl/ddfs_pkg.sv
// Shared types and range helpers for the DDFS divider range controller.
package ddfs_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        APPLY     = 2'd2,
        SETTLE    = 2'd3
    } state_e;

    localparam int unsigned RANGE_MIN = 0;
    localparam int unsigned RANGE_MAX = 6;
    localparam int unsigned RANGE_W   = 3;

    // Code 7 is not a legal divider range; fold it onto the top range.
    function automatic logic [RANGE_W-1:0] clamp_range(input logic [RANGE_W-1:0] r);
        return (r > RANGE_W'(RANGE_MAX)) ? RANGE_W'(RANGE_MAX) : r;
    endfunction

    function automatic logic [RANGE_W-1:0] next_range(input logic [RANGE_W-1:0] r);
        return (r >= RANGE_W'(RANGE_MAX)) ? RANGE_W'(RANGE_MIN) : r + 1'b1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddfs_cycle_timer.sv
// Loadable down-counter that sticks at zero; load takes priority over count.
module ddfs_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddfs_range_ctrl.sv
// Range-change sequencer for the DDFS divider: switches freq_cntrl on a
// div_clk falling edge (or after a timeout), pulses the divider reset, settles.
module ddfs_range_ctrl
    import ddfs_pkg::*;
#(
    parameter int unsigned RESET_RANGE = 3,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned DWELL_CYC   = 50000000
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [RANGE_W-1:0] req_range,
    output logic               req_ready,
    input  logic               sweep_en,
    input  logic               div_clk,
    output logic [RANGE_W-1:0] freq_cntrl,
    output logic               div_rst_n,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = $clog2(max3(TIMEOUT_CYC, DWELL_CYC, SETTLE_CYC)) + 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] DWELL_LOAD   = (DWELL_CYC > 0) ? CNT_W'(DWELL_CYC - 1) : '0;

    state_e             state_q, state_d;
    logic [RANGE_W-1:0] freq_q, freq_d;
    logic [RANGE_W-1:0] pending_q, pending_d;
    logic               div_rst_n_q, div_rst_n_d;
    logic               done_q, done_d;
    logic               div_prev_q;

    logic               tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0]   tmr_val;
    logic               dwell_load, dwell_en, dwell_zero;

    logic               accept;
    logic               fall;
    logic [RANGE_W-1:0] req_cl;

    assign accept = req_valid && (state_q == IDLE);
    assign fall   = div_prev_q && !div_clk;
    assign req_cl = clamp_range(req_range);

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        pending_d   = pending_q;
        div_rst_n_d = 1'b1;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = TIMEOUT_LOAD;
        tmr_en      = 1'b0;
        dwell_load  = 1'b0;
        dwell_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                dwell_en = sweep_en;
                // External request wins; a coincident sweep step is dropped.
                if (accept) begin
                    dwell_load = 1'b1;
                    if (req_cl == freq_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = req_cl;
                        tmr_load  = 1'b1;
                        state_d   = WAIT_EDGE;
                    end
                end else if (!sweep_en) begin
                    dwell_load = 1'b1;
                end else if (dwell_zero) begin
                    pending_d = next_range(freq_q);
                    tmr_load  = 1'b1;
                    state_d   = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (fall || tmr_zero) begin
                    state_d = APPLY;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            APPLY: begin
                freq_d      = pending_q;
                div_rst_n_d = 1'b0;
                tmr_load    = 1'b1;
                tmr_val     = SETTLE_LOAD;
                state_d     = SETTLE;
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    dwell_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            freq_q      <= RANGE_W'(RESET_RANGE);
            pending_q   <= RANGE_W'(RESET_RANGE);
            div_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            div_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_q      <= freq_d;
            pending_q   <= pending_d;
            div_rst_n_q <= div_rst_n_d;
            done_q      <= done_d;
            div_prev_q  <= div_clk;
        end
    end

    // Shared between the edge timeout and the post-reset settle window.
    ddfs_cycle_timer #(
        .W (CNT_W)
    ) u_step_timer (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    ddfs_cycle_timer #(
        .W (CNT_W)
    ) u_dwell_timer (
        .clk_i      (clk_in),
        .rst_ni     (rst_n),
        .load_i     (dwell_load),
        .load_val_i (DWELL_LOAD),
        .en_i       (dwell_en),
        .zero_o     (dwell_zero)
    );

    assign freq_cntrl = freq_q;
    assign div_rst_n  = div_rst_n_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
    assign req_ready  = (state_q == IDLE);

endmodule
